// File: rtl/redun_mont_sq_ctrl.sv
// Sequencer for the redundant-form Montgomery squaring loop: owns the operand register
// and iteration counter, launches T chained squarings and schedules equalize passes.
module redun_mont_sq_ctrl #(
   parameter int WRD_BITS           = 16,
   parameter int NUM_WRDS           = 65,
   parameter int T_LEN              = 64,
   parameter int BOUNDARY_THRESHOLD = 2,
   localparam int RW                = NUM_WRDS * (WRD_BITS + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [RW-1:0]    i_sq,
   input  logic [T_LEN-1:0] i_t,
   output logic             o_busy,
   output logic             o_mul_val,
   output logic [RW-1:0]    o_mul_sq,
   output logic             o_mul_eq,
   input  logic             i_mul_val,
   input  logic [RW-1:0]    i_mul_sq,
   input  logic             i_mul_carry,
   output logic             o_done,
   output logic [RW-1:0]    o_sq,
   output logic [T_LEN-1:0] o_cnt,
   output logic             o_err
);

   localparam int EQW = $clog2(BOUNDARY_THRESHOLD + 1);
   localparam logic [EQW-1:0] EQ_LIM = EQW'(BOUNDARY_THRESHOLD - 1);
   localparam logic [T_LEN-1:0] ONE = T_LEN'(1);

   // Handshake: o_mul_val and i_mul_val are single-cycle pulses; o_mul_sq/o_mul_eq are
   // valid with o_mul_val, i_mul_sq/i_mul_carry with i_mul_val. No backpressure exists.
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

   state_t           state;
   logic [T_LEN-1:0] rem;
   logic [EQW-1:0]   eq_cnt;

   // o_mul_sq doubles as the operand register. The pending carry is folded straight into
   // the registered o_mul_eq when the next launch is scheduled, so no separate flop holds it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         rem       <= '0;
         eq_cnt    <= '0;
         o_busy    <= 1'b0;
         o_mul_val <= 1'b0;
         o_mul_sq  <= '0;
         o_mul_eq  <= 1'b0;
         o_done    <= 1'b0;
         o_sq      <= '0;
         o_cnt     <= '0;
         o_err     <= 1'b0;
      end else begin
         o_mul_val <= 1'b0;
         o_done    <= 1'b0;
         if (i_mul_val && state != WAIT) o_err <= 1'b1;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_mul_sq <= i_sq;
                  rem      <= i_t;
                  o_cnt    <= '0;
                  o_err    <= 1'b0;
                  eq_cnt   <= '0;
                  if (i_t != '0) begin
                     state     <= LAUNCH;
                     o_busy    <= 1'b1;
                     o_mul_val <= 1'b1;
                     o_mul_eq  <= (BOUNDARY_THRESHOLD <= 1);
                  end else begin
                     state  <= DONE;
                     o_done <= 1'b1;
                     o_sq   <= i_sq;
                  end
               end
            end
            LAUNCH: begin
               eq_cnt <= o_mul_eq ? '0 : eq_cnt + 1'b1;
               state  <= WAIT;
            end
            WAIT: begin
               if (i_mul_val) begin
                  o_mul_sq <= i_mul_sq;
                  o_cnt    <= o_cnt + 1'b1;
                  rem      <= rem - 1'b1;
                  if (rem != ONE) begin
                     state     <= LAUNCH;
                     o_mul_val <= 1'b1;
                     o_mul_eq  <= i_mul_carry | (eq_cnt >= EQ_LIM);
                  end else begin
                     state  <= DONE;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                     o_sq   <= i_mul_sq;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_redun_mont_sq_ctrl.sv
// Bench for redun_mont_sq_ctrl: a behavioural multiplier with programmable latency and
// carry pattern drives two instances (equalize threshold 2 and 3) from the same stimulus.
module tb_redun_mont_sq_ctrl;

   localparam int RW    = 65 * 17;
   localparam int T_LEN = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [RW-1:0]    sq_in = '0;
   logic [T_LEN-1:0] t_in = '0;
   logic             mul_val = 1'b0;
   logic [RW-1:0]    mul_sq = '0;
   logic             mul_carry = 1'b0;

   logic a_busy, a_mul_val, a_mul_eq, a_done, a_err;
   logic b_busy, b_mul_val, b_mul_eq, b_done, b_err;
   logic [RW-1:0] a_mul_sq, a_sq, b_mul_sq, b_sq;
   logic [T_LEN-1:0] a_cnt, b_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   redun_mont_sq_ctrl #(.BOUNDARY_THRESHOLD(2)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_sq(sq_in), .i_t(t_in),
      .o_busy(a_busy), .o_mul_val(a_mul_val), .o_mul_sq(a_mul_sq), .o_mul_eq(a_mul_eq),
      .i_mul_val(mul_val), .i_mul_sq(mul_sq), .i_mul_carry(mul_carry),
      .o_done(a_done), .o_sq(a_sq), .o_cnt(a_cnt), .o_err(a_err));

   redun_mont_sq_ctrl #(.BOUNDARY_THRESHOLD(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_sq(sq_in), .i_t(t_in),
      .o_busy(b_busy), .o_mul_val(b_mul_val), .o_mul_sq(b_mul_sq), .o_mul_eq(b_mul_eq),
      .i_mul_val(mul_val), .i_mul_sq(mul_sq), .i_mul_carry(mul_carry),
      .o_done(b_done), .o_sq(b_sq), .o_cnt(b_cnt), .o_err(b_err));

   typedef struct {
      logic [63:0] t;
      int          lat;
      logic [31:0] cmask;
      logic [31:0] e2;
      logic [31:0] e3;
      bit          stray;
   } vec_t;

   vec_t tbl[8];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic void chk_w(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ...%016h want ...%016h", nm, act[63:0], exp[63:0]);
      end
   endfunction

   // Stand-in for one modular squaring; any deterministic wide map exercises the feedback.
   function automatic logic [RW-1:0] sq_f(logic [RW-1:0] x);
      logic [RW-1:0] p;
      p = x * x;
      return p + RW'(3);
   endfunction

   function automatic logic [RW-1:0] ref_sq(logic [RW-1:0] x, int t);
      logic [RW-1:0] v;
      v = x;
      for (int i = 0; i < t; i++) v = sq_f(v);
      return v;
   endfunction

   // Launch k equalizes when result k-1 carried, or when the th-1 launches before it
   // all exist in this run and none of them equalized.
   function automatic logic [31:0] eq_model(int t, logic [31:0] cm, int th);
      logic [31:0] m;
      bit plain;
      m = '0;
      for (int k = 0; k < t && k < 32; k++) begin
         plain = (k >= th - 1);
         for (int j = 1; j < th; j++)
            if (k - j >= 0 && m[k-j]) plain = 1'b0;
         m[k] = (k > 0 && cm[k-1]) | plain;
      end
      return m;
   endfunction

   function automatic logic [RW-1:0] rand_w();
      logic [RW-1:0] v;
      v = '0;
      for (int i = 0; i < (RW + 31) / 32; i++) v = {v[RW-33:0], 32'($urandom)};
      return v;
   endfunction

   task automatic chk_zero(string tag);
      chk({tag, " busy"}, 64'(a_busy), 0);
      chk({tag, " mul_val"}, 64'(a_mul_val), 0);
      chk({tag, " mul_eq"}, 64'(a_mul_eq), 0);
      chk({tag, " done"}, 64'(a_done), 0);
      chk({tag, " cnt"}, a_cnt, 0);
      chk({tag, " err"}, 64'(a_err), 0);
      chk_w({tag, " sq"}, a_sq, '0);
      chk_w({tag, " mul_sq"}, a_mul_sq, '0);
      chk({tag, " b_cnt"}, b_cnt, 0);
   endtask

   task automatic run_job(string tag, logic [63:0] t, int lat, logic [RW-1:0] x0,
                          logic [31:0] cm, logic [31:0] e2, logic [31:0] e3,
                          bit stray, int abort_at);
      logic [31:0] g2, g3;
      logic [RW-1:0] cur, exp_fin;
      int launches, launches_b, cd, k, done_k, limit, res;
      bit op_bad, busy_bad;
      g2 = '0; g3 = '0; launches = 0; launches_b = 0; cd = -1; done_k = -1; res = 0;
      op_bad = 0; busy_bad = 0;
      cur = x0;
      exp_fin = ref_sq(x0, int'(t));
      sq_in = x0; t_in = t; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 1;
      limit = int'(t) * (lat + 1) + 20;
      while (k <= limit) begin
         if (a_mul_val) begin
            if (a_mul_sq !== cur || b_mul_sq !== cur) op_bad = 1;
            if (launches < 32) g2[launches] = a_mul_eq;
            launches++;
            cur = sq_f(cur);
            cd = lat;
         end
         if (b_mul_val) begin
            if (launches_b < 32) g3[launches_b] = b_mul_eq;
            launches_b++;
         end
         if (a_done) begin
            done_k = k;
            break;
         end
         if (!a_busy || !b_busy) busy_bad = 1;
         if (abort_at > 0 && launches == abort_at && !a_mul_val) begin
            rst = 1'b1;
            mul_val = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         mul_val = 1'b0;
         mul_carry = 1'b0;
         if (cd == 0) begin
            mul_val = 1'b1;
            mul_sq = cur;
            mul_carry = (res < 32) ? cm[res] : 1'b0;
            res++;
            cd = -1;
         end else if (cd > 0) begin
            cd--;
         end
         if (stray && k == 2) begin
            start = 1'b1; t_in = 64'd7; sq_in = ~x0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      mul_val = 1'b0; mul_carry = 1'b0; start = 1'b0;
      chk({tag, " done latency"}, 64'(done_k), 64'(1 + int'(t) * (lat + 1)));
      chk({tag, " launches"}, 64'(launches), t);
      chk({tag, " launches th3"}, 64'(launches_b), t);
      chk({tag, " eq pattern th2"}, 64'(g2), 64'(e2));
      chk({tag, " eq pattern th3"}, 64'(g3), 64'(e3));
      chk({tag, " operands"}, 64'(op_bad), 0);
      chk({tag, " busy during run"}, 64'(busy_bad), 0);
      chk({tag, " busy at done"}, 64'(a_busy), 0);
      chk_w({tag, " o_sq"}, a_sq, exp_fin);
      chk_w({tag, " o_sq th3"}, b_sq, exp_fin);
      chk({tag, " o_cnt"}, a_cnt, t);
      chk({tag, " o_cnt th3"}, b_cnt, t);
      chk({tag, " done th3"}, 64'(b_done), 1);
      chk({tag, " err"}, 64'(a_err | b_err), 0);
      @(posedge clk); #1;
      chk({tag, " done pulse width"}, 64'(a_done), 0);
      chk_w({tag, " o_sq hold"}, a_sq, exp_fin);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{t: 64'd0, lat: 2, cmask: 32'h0, e2: 32'h00, e3: 32'h00, stray: 1'b0};
      tbl[1] = '{t: 64'd1, lat: 3, cmask: 32'h0, e2: 32'h00, e3: 32'h00, stray: 1'b0};
      tbl[2] = '{t: 64'd5, lat: 1, cmask: 32'h0, e2: 32'h0A, e3: 32'h04, stray: 1'b0};
      tbl[3] = '{t: 64'd4, lat: 2, cmask: 32'h1, e2: 32'h0A, e3: 32'h02, stray: 1'b1};
      tbl[4] = '{t: 64'd4, lat: 2, cmask: 32'h2, e2: 32'h06, e3: 32'h04, stray: 1'b0};
      tbl[5] = '{t: 64'd4, lat: 1, cmask: 32'h8, e2: 32'h0A, e3: 32'h04, stray: 1'b0};
      tbl[6] = '{t: 64'd3, lat: 4, cmask: 32'h7, e2: 32'h06, e3: 32'h06, stray: 1'b0};
      tbl[7] = '{t: 64'd6, lat: 1, cmask: 32'h0, e2: 32'h2A, e3: 32'h24, stray: 1'b1};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         run_job($sformatf("vec%0d", i), tbl[i].t, tbl[i].lat, rand_w(), tbl[i].cmask,
                 tbl[i].e2, tbl[i].e3, tbl[i].stray, 0);

      // Stray result while idle: flagged, data ignored, cleared by the next accepted start.
      mul_val = 1'b1; mul_sq = rand_w(); mul_carry = 1'b1;
      @(posedge clk); #1;
      mul_val = 1'b0; mul_carry = 1'b0;
      chk("stray err", 64'(a_err), 1);
      chk("stray cnt kept", a_cnt, tbl[7].t);
      repeat (3) @(posedge clk);
      #1;
      chk("stray err sticky", 64'(b_err), 1);
      run_job("after stray", 64'd2, 2, rand_w(), 32'h0, 32'h2, 32'h0, 1'b0, 0);

      // Reset while waiting on the third result of a ten-squaring run.
      run_job("abort", 64'd10, 3, rand_w(), 32'h0, 32'h0, 32'h0, 1'b0, 3);
      chk_zero("abort reset");
      mul_val = 1'b1; mul_sq = rand_w();
      @(posedge clk); #1;
      mul_val = 1'b0;
      chk("late result err", 64'(a_err), 1);
      chk("late result cnt", a_cnt, 0);
      run_job("post abort", 64'd2, 2, rand_w(), 32'h0, 32'h2, 32'h0, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         logic [63:0] rt;
         int rl;
         logic [31:0] rc;
         rt = 64'($urandom_range(0, 10));
         rl = $urandom_range(1, 4);
         rc = $urandom;
         run_job($sformatf("rand%0d", i), rt, rl, rand_w(), rc,
                 eq_model(int'(rt), rc, 2), eq_model(int'(rt), rc, 3), 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
